cond_flag_unit: RTL

COND_FLAG_UNIT -- requirements
Module: cond_flag_unit

---
 rtl/cond_flag_unit.sv | 109 ++++++++++
 1 files changed

// File: rtl/cond_flag_unit.sv
// Condition-code unit: holds the architectural NZCV register, evaluates ID-stage conditions, stalls on flag hazards.
// Build option: define COND_FLAG_FWD_EN to forward EX flags into the evaluation instead of stalling.
module cond_flag_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  alu_flags,
    input  logic        s_bit,
    input  logic [3:0]  cond,
    input  logic        cond_valid,
    output logic        cond_true,
    output logic        stall,
    output logic [3:0]  flags_q,
    output logic        carry_out,
    output logic [15:0] fail_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [3:0] COND_AL = 4'b1110;

    state_t      state;
    state_t      state_next;
    logic        hazard;
    logic [3:0]  eff_flags;
    logic        cond_pass;
    logic        fail_evt;

    function automatic logic eval_cond(input logic [3:0] code, input logic [3:0] f);
        logic n, z, c, v;
        logic r;
        {n, z, c, v} = f;
        case (code)
            4'b0000: r = z;
            4'b0001: r = !z;
            4'b0010: r = c;
            4'b0011: r = !c;
            4'b0100: r = n;
            4'b0101: r = !n;
            4'b0110: r = v;
            4'b0111: r = !v;
            4'b1000: r = c & !z;
            4'b1001: r = !c | z;
            4'b1010: r = (n == v);
            4'b1011: r = (n != v);
            4'b1100: r = !z & (n == v);
            4'b1101: r = z | (n != v);
            4'b1110: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Forwarding resolves the hazard in place, so HOLD is never entered.
    always_comb begin
`ifdef COND_FLAG_FWD_EN
        eff_flags = (state == IDLE && s_bit) ? alu_flags : flags_q;
        hazard    = 1'b0;
`else
        eff_flags = flags_q;
        hazard    = (state == IDLE) && cond_valid && s_bit && (cond != COND_AL);
`endif
    end

    assign cond_pass = eval_cond(cond, eff_flags);

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (hazard) begin
                    stall      = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (reset) begin
            stall = 1'b0;
        end
        cond_true = cond_valid && !stall && !reset && cond_pass;
        fail_evt  = cond_valid && !stall && !cond_true;
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            flags_q  <= 4'b0000;
            fail_cnt <= 16'h0000;
        end else begin
            state <= state_next;
            if (s_bit) begin
                flags_q <= alu_flags;
            end
            if (fail_evt && fail_cnt != 16'hFFFF) begin
                fail_cnt <= fail_cnt + 16'd1;
            end
        end
    end

    assign carry_out = flags_q[1];

endmodule
